// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port RAM with a tristate data bus.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 1 wins ties, no last pointer).
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rwn_o,
    output logic              mem_en_o,
    inout  wire  [DATA_W-1:0] mem_data_io
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ACK} state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              rwn_q, rwn_d;
    logic              en_q, en_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              win;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rwn_q    <= 1'b1;
            en_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rwn_q    <= rwn_d;
            en_q     <= en_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rwn_d    = 1'b1;
        en_d     = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        win      = req1_i;
`else
        last_d   = last_q;
        win      = (req0_i && req1_i) ? ~last_q : req1_i;
`endif

        // Outputs are computed for the state being entered so they come out registered.
        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    state_d = S_SETUP;
                    grant_d = win;
                    we_d    = win ? we1_i    : we0_i;
                    addr_d  = win ? addr1_i  : addr0_i;
                    wdata_d = win ? wdata1_i : wdata0_i;
                    rwn_d   = ~we_d;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                rwn_d   = ~we_q;
                en_d    = 1'b1;
            end
            S_ACCESS: begin
                state_d = S_ACK;
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                if (!we_q) begin
                    if (grant_q) rdata1_d = mem_data_io;
                    else         rdata0_d = mem_data_io;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                last_d  = grant_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign mem_data_io = rwn_q ? {DATA_W{1'bz}} : wdata_q;

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign rdata0_o   = rdata0_q;
    assign rdata1_o   = rdata1_q;
    assign busy_o     = busy_q;
    assign mem_addr_o = addr_q;
    assign mem_rwn_o  = rwn_q;
    assign mem_en_o   = en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM on the tristate bus.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, busy, mem_rwn, mem_en;
    logic [7:0] rdata0, rdata1, mem_addr;
    wire  [7:0] mem_data;

    logic [7:0] ram [256];
    logic       pre_we;
    logic [7:0] pre_addr, pre_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
        .busy_o(busy), .mem_addr_o(mem_addr), .mem_rwn_o(mem_rwn), .mem_en_o(mem_en),
        .mem_data_io(mem_data)
    );

    // RAM drives the bus on enabled reads; it shares the system reset, so a write
    // cut off by reset is never committed.
    assign mem_data = (mem_en && mem_rwn) ? ram[mem_addr] : 8'bz;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_en && !mem_rwn && !rst) ram[mem_addr] <= mem_data;
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++; if (mem_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        vectors++; if (mem_rwn !== 1'b1) begin miscompares++; $display("FAIL reset_rwn: got %b want 1", mem_rwn); end
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b want 0", mem_en); end
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b%b want 00", ack0, ack1); end
        vectors++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 00/00", rdata0, rdata1); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'hFF; wdata0 = 8'h06;
        @(negedge clk);
        vectors++; if (mem_rwn !== 1'b0 || mem_en !== 1'b0) begin miscompares++; $display("FAIL wr_setup_ctl: got rwn=%b en=%b want 0/0", mem_rwn, mem_en); end
        vectors++; if (mem_addr !== 8'hFF) begin miscompares++; $display("FAIL wr_setup_addr: got %h want ff", mem_addr); end
        vectors++; if (mem_data !== 8'h06) begin miscompares++; $display("FAIL wr_setup_data: got %h want 06", mem_data); end
        vectors++; if (busy !== 1'b1 || ack0 !== 1'b0) begin miscompares++; $display("FAIL wr_setup_busy_ack: got %b/%b want 1/0", busy, ack0); end
        @(negedge clk);
        vectors++; if (mem_rwn !== 1'b0 || mem_en !== 1'b1) begin miscompares++; $display("FAIL wr_access_ctl: got rwn=%b en=%b want 0/1", mem_rwn, mem_en); end
        vectors++; if (mem_data !== 8'h06) begin miscompares++; $display("FAIL wr_access_data: got %h want 06", mem_data); end
        @(negedge clk);
        vectors++; if (ack0 !== 1'b1 || ack1 !== 1'b0) begin miscompares++; $display("FAIL wr_ack: got %b%b want 10", ack0, ack1); end
        vectors++; if (mem_rwn !== 1'b1 || mem_en !== 1'b0) begin miscompares++; $display("FAIL wr_ack_ctl: got rwn=%b en=%b want 1/0", mem_rwn, mem_en); end
        vectors++; if (rdata0 !== 8'h00) begin miscompares++; $display("FAIL wr_rdata0_hold: got %h want 00", rdata0); end
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        vectors++; if (ack0 !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_idle: got ack0=%b busy=%b want 0/0", ack0, busy); end
        vectors++; if (ram[8'hFF] !== 8'h06) begin miscompares++; $display("FAIL wr_ram: got %h want 06", ram[8'hFF]); end
    endtask

    task automatic test_read_p1();
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
        @(negedge clk);
        vectors++; if (mem_rwn !== 1'b1 || mem_en !== 1'b0 || mem_addr !== 8'hFF) begin miscompares++; $display("FAIL rd_setup: got rwn=%b en=%b addr=%h want 1/0/ff", mem_rwn, mem_en, mem_addr); end
        @(negedge clk);
        vectors++; if (mem_en !== 1'b1 || mem_rwn !== 1'b1) begin miscompares++; $display("FAIL rd_access_ctl: got rwn=%b en=%b want 1/1", mem_rwn, mem_en); end
        @(negedge clk);
        vectors++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin miscompares++; $display("FAIL rd_ack: got %b%b want 01", ack0, ack1); end
        vectors++; if (rdata1 !== 8'h06) begin miscompares++; $display("FAIL rd_rdata1: got %h want 06", rdata1); end
        vectors++; if (rdata0 !== 8'h00) begin miscompares++; $display("FAIL rd_rdata0_hold: got %h want 00", rdata0); end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        vectors++; if (ack1 !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rd_idle: got ack1=%b busy=%b want 0/0", ack1, busy); end
    endtask

    task automatic test_tie_order();
        logic first;
        logic e0, e1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        preload(8'hFE, 8'h08);
        preload(8'hFD, 8'h0A);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'hFE;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFD;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin if (first) req1 = 1'b0; else req0 = 1'b0; end
            if (c == 8) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
            e0 = first ? (c == 7) : (c == 3);
            e1 = first ? (c == 3) : (c == 7);
            vectors++; if (ack0 !== e0 || ack1 !== e1) begin miscompares++; $display("FAIL tie_ack c=%0d: got %b%b want %b%b", c, ack0, ack1, e0, e1); end
            if (e0) begin vectors++; if (rdata0 !== 8'h08) begin miscompares++; $display("FAIL tie_rdata0: got %h want 08", rdata0); end end
            if (e1) begin vectors++; if (rdata1 !== 8'h0A) begin miscompares++; $display("FAIL tie_rdata1: got %h want 0a", rdata1); end end
        end
    endtask

    task automatic test_back_to_back();
        logic nxt;
        logic e0, e1;
        int   acks;
        acks = 0;
        nxt  = 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
        nxt  = 1'b0;
`endif
        preload(8'h10, 8'hA1);
        preload(8'h20, 8'hB2);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            e0 = ((c % 4) == 3) && (nxt == 1'b0);
            e1 = ((c % 4) == 3) && (nxt == 1'b1);
            vectors++; if (ack0 !== e0 || ack1 !== e1) begin miscompares++; $display("FAIL b2b_ack c=%0d: got %b%b want %b%b", c, ack0, ack1, e0, e1); end
            if (e0) begin vectors++; if (rdata0 !== 8'hA1) begin miscompares++; $display("FAIL b2b_rdata0 c=%0d: got %h want a1", c, rdata0); end end
            if (e1) begin vectors++; if (rdata1 !== 8'hB2) begin miscompares++; $display("FAIL b2b_rdata1 c=%0d: got %h want b2", c, rdata1); end end
            if (ack0 || ack1) acks++;
            if ((c % 4) == 3) begin
`ifndef MEM_ARB_FIXED_PRIO_EN
                nxt = ~nxt;
`endif
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        vectors++; if (acks != 8) begin miscompares++; $display("FAIL b2b_ack_count: got %0d want 8", acks); end
    endtask

    task automatic test_reset_mid_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'hFD; wdata0 = 8'h55;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (mem_en !== 1'b1 || mem_rwn !== 1'b0) begin miscompares++; $display("FAIL rst_mid_access: got rwn=%b en=%b want 0/1", mem_rwn, mem_en); end
        rst = 1'b1; req0 = 1'b0; we0 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        vectors++; if (mem_en !== 1'b0 || mem_rwn !== 1'b1 || mem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_mid_ctl: got rwn=%b en=%b addr=%h want 1/0/00", mem_rwn, mem_en, mem_addr); end
        vectors++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_ack_busy: got ack=%b%b busy=%b want 00/0", ack0, ack1, busy); end
        vectors++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin miscompares++; $display("FAIL rst_mid_rdata: got %h/%h want 00/00", rdata0, rdata1); end
        @(negedge clk);
        vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("FAIL rst_mid_late_ack: got %b want 0", ack0); end
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFD;
        repeat (3) @(negedge clk);
        vectors++; if (ack1 !== 1'b1 || rdata1 !== 8'h0A) begin miscompares++; $display("FAIL rst_mid_readback: got ack1=%b rdata1=%h want 1/0a", ack1, rdata1); end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_change();
        preload(8'h30, 8'hC3);
        preload(8'h31, 8'h3C);
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
        @(posedge clk); #1;
        addr0 = 8'h31; we0 = 1'b1; wdata0 = 8'hFF;
        @(negedge clk);
        vectors++; if (mem_addr !== 8'h30 || mem_rwn !== 1'b1) begin miscompares++; $display("FAIL chg_setup: got addr=%h rwn=%b want 30/1", mem_addr, mem_rwn); end
        @(negedge clk);
        vectors++; if (mem_addr !== 8'h30 || mem_rwn !== 1'b1 || mem_en !== 1'b1) begin miscompares++; $display("FAIL chg_access: got addr=%h rwn=%b en=%b want 30/1/1", mem_addr, mem_rwn, mem_en); end
        @(negedge clk);
        vectors++; if (ack0 !== 1'b1 || rdata0 !== 8'hC3) begin miscompares++; $display("FAIL chg_ack: got ack0=%b rdata0=%h want 1/c3", ack0, rdata0); end
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        vectors++; if (ram[8'h31] !== 8'h3C) begin miscompares++; $display("FAIL chg_ram31: got %h want 3c", ram[8'h31]); end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        test_reset();
        test_write();
        test_read_p1();
        test_tie_order();
        test_back_to_back();
        test_reset_mid_write();
        test_addr_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the processor's single-port RAM (8-bit address, bidirectional 8-bit data bus, `rwn` read/write-not, `enable`). It sits between the instruction-fetch port (port 0) and the load/store port (port 1) and the RAM. It grants the RAM to one requester at a time, drives address, `rwn`, `enable` and the tristate data bus in a fixed sequence, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  access request, ports 0/1
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  ADDR_W  access address
- `wdata0` / `wdata1`  in  DATA_W  write data
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  read data, registered per port
- `busy`  out  1  high in any state other than IDLE
- `mem_addr`  out  ADDR_W  to RAM address
- `mem_rwn`  out  1  to RAM; 1 = read, 0 = write
- `mem_en`  out  1  to RAM enable
- `mem_data`  inout  DATA_W  RAM data bus; driven only during writes, else high-Z

## Operation
- FSM states: IDLE, SETUP, ACCESS, ACK.
- IDLE: if any `req` is high, pick a winner, latch its `we`, `addr` and `wdata` into internal registers, store the grant index, then go to SETUP. If no request, stay in IDLE.
- Arbitration is round-robin. A `last` pointer records the most recently served port. On a tie, the port other than `last` wins. With a single request, that port wins.
- SETUP: `mem_addr` = latched address, `mem_rwn` = ~we, `mem_en` = 0. For writes, drive `mem_data` = latched wdata. Go to ACCESS.
- ACCESS: same as SETUP, plus `mem_en` = 1. For reads, capture `mem_data` into the granted port's `rdata` at the end of the cycle. Go to ACK.
- ACK: `ack` of the granted port = 1, `mem_en` = 0, `mem_rwn` = 1, `mem_data` = Z. Set `last` to the granted port. Go to IDLE.
- `rdata` of a port changes only on that port's reads. It holds its value across other accesses and across writes.
- Requester rule: hold `req`, `we`, `addr` and `wdata` stable from assertion until `ack` is seen, then deassert `req` at the next edge. A `req` still high in the IDLE cycle after ACK counts as a new request.
- Inputs change after the IDLE latch have no effect on an access in flight.
- The non-granted port's `req` is ignored until the next IDLE.

## Timing
- Reset values: state IDLE, `mem_addr` = 0, `mem_rwn` = 1, `mem_en` = 0, `mem_data` = Z, `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0, `last` = 1 (port 0 wins the first tie).
- Latency: `req` high at edge N (state IDLE), then SETUP at N+1, ACCESS at N+2, ACK at N+3. The access takes 4 cycles, with `ack` high for exactly cycle N+3.
- Throughput: at most one access every 4 cycles. Both ports continuously requesting alternate 0, 1, 0, 1, …
- All outputs are registered. `mem_rwn` = 0 only in SETUP and ACCESS of a write, so the bus turns around with `mem_en` low on both sides.
- `mem_data` is driven exactly when `mem_rwn` = 0. The arbiter and RAM never drive the bus at the same time.
- Reset mid-access (any state): next edge forces reset values. The pending access is dropped with no `ack`, and a write is aborted.
- Address wrap is not applicable; the full `ADDR_W` range is passed through unchanged.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. Port 1 (load/store) always wins a tie, and the `last` pointer is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then port 0 writes 0x06 to 0xFF: `mem_rwn` = 0 for 2 cycles, `mem_en` = 1 in the 2nd, `ack0` at cycle 3. Afterwards `mem_data` is Z and `mem_rwn` = 1.
- Port 1 reads 0xFF after the previous write: `rdata1` = 0x06 with `ack1`, and `rdata0` is unchanged.
- Both ports request reads from reset (0xFE, 0xFD preloaded 0x08, 0x0A): port 0 is served first (0x08) and port 1 4 cycles later (0x0A). With `MEM_ARB_FIXED_PRIO_EN` defined, the order is reversed.
- Both `req` held high continuously for 8 accesses: grants alternate 0, 1, 0, 1, …, one `ack` every 4 cycles, never both in the same cycle.
- `rst` asserted during ACCESS of a write to 0xFD: next cycle all outputs are at reset values with no `ack`. A subsequent read of 0xFD returns its prior value.
- Port 0 changes `addr0` during SETUP: the RAM still sees the address latched in IDLE.
